load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the execute stage and data_mem; converts core load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into data_mem word accesses.
- data_mem always writes 4 bytes, so SB/SH are done as read-modify-write: read word, merge, write back.
- Loads are sign/zero-extended; one response pulse per accepted request.

Parameters:
- ADDR_W, 32, address width (matches data_mem addr)
- DATA_W, 32, data width (fixed at 32; merge logic assumes 4 bytes)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  LSU idle, can accept
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data (low bytes used for SB/SH)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  extended load data; 0 for stores/errors
- resp_err  out  1  illegal funct3 (or misaligned, see feature); valid with resp_valid
- mem_rw  out  1  to data_mem rw: 1=read, 0=write
- mem_addr  out  ADDR_W  to data_mem addr
- mem_wdata  out  DATA_W  to data_mem write_data
- mem_rdata  in  DATA_W  from data_mem read_data (combinational)

Behaviour:
- Reset (rst=0, async): state IDLE; mem_rw=1, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_err=0. The in-flight request is dropped and no write occurs.
- mem_rw=0 only in WRITE; in all other states and during reset it is 1, because data_mem writes on every clk edge with rw=0.
- States: IDLE, ACCESS, WRITE, RESP.
  - IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata, then:
    - legal request -> ACCESS
    - illegal funct3 -> RESP with err=1
  - ACCESS: mem_addr=addr_q.
    - Load: mem_rw=1; capture extended mem_rdata -> RESP.
    - SW: mem_rw=0, mem_wdata=wdata_q; write at edge -> RESP.
    - SB/SH: mem_rw=1; capture raw word -> WRITE.
  - WRITE (SB/SH only): mem_rw=0, mem_addr=addr_q.
    - SB: mem_wdata = {word[31:8], wdata_q[7:0]}
    - SH: mem_wdata = {word[31:16], wdata_q[15:0]}
    - then -> RESP.
  - RESP: resp_valid=1 for exactly one cycle with rdata/err; req_ready=0 -> IDLE.
- Latency (accept edge = cycle 0):
  - resp_valid high in cycle 2 for loads/SW, cycle 3 for SB/SH, cycle 1 for illegal requests.
  - Next accept possible in the cycle after RESP.
- Extension:
  - LB = {{24{b7}}, b[7:0]}, LBU zero-extends.
  - LH = {{16{b15}}, b[15:0]}, LHU zero-extends.
  - LW passes through.
- Illegal funct3: 011/110/111 for loads; any value other than 000/001/010 for stores. No memory access; resp_err=1, resp_rdata=0.
- Address arithmetic is mod 2^ADDR_W. An access at 0xFFFFFFFD touches bytes wrapping to 0; the LSU adds nothing.
- req_valid while not ready is ignored and must be held by the upstream stage. No resp backpressure.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, goes IDLE -> RESP with resp_err=1, rdata=0 and no memory access (mem_rw stays 1).
- Undefined: misaligned accesses proceed normally at the byte address, since data_mem is byte-addressable.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU
  - 2-bit state encoding localparams S_IDLE/S_ACCESS/S_WRITE/S_RESP
  - function is_legal(we, funct3)
- One combinational sub-module, lsu_data_align: load extension plus SB/SH store merge, shared by ACCESS/WRITE. FSM and registers stay in load_store_unit.

Test Plan:
- After reset (data_mem holds byte i at address i), LW 0x10 -> resp_rdata=0x13121110, resp_err=0, resp_valid in cycle 2; mem_rw never 0.
- LB 0x80 -> 0xFFFFFF80; LBU 0x80 -> 0x00000080; LH 0x82 -> 0xFFFF8382; LHU 0x82 -> 0x00008382.
- SB 0x20, wdata 0xDEADBEAB -> mem_rw=0 only in cycle 2 with mem_wdata=0x232221AB; resp in cycle 3; following LW 0x20 -> 0x232221AB. SH 0x40, wdata 0x1234 -> LW 0x40 = 0x43421234.
- Load with funct3=011 -> resp_valid in cycle 1, resp_err=1, rdata=0, no write. SW with funct3=100 -> same.
- Misaligned LW 0x11:
  - with LSU_MISALIGN_TRAP_EN -> err=1, no access
  - without -> rdata=0x14131211, err=0
- rst pulled low during the WRITE state of SB 0x30 -> mem_rw=1 immediately, state IDLE, no resp_valid; a subsequent LW 0x30 after the re-reset initialisation returns 0x33323130.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, state encoding and legality helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_WRITE  = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = S_IDLE,
      ST_ACCESS = S_ACCESS,
      ST_WRITE  = S_WRITE,
      ST_RESP   = S_RESP
   } lsu_state_t;

   function automatic logic is_legal(input logic we, input logic [2:0] funct3);
      logic ok;
      case (funct3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = ~we;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic mis;
      case (funct3)
         F3_H, F3_HU: mis = addr_lo[0];
         F3_W:        mis = (addr_lo != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational data path of the LSU: load sign/zero extension and SB/SH read-modify-write merge.
module lsu_data_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32
)
(
   input  logic [2:0]        i_funct3,
   input  logic [DATA_W-1:0] i_word,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_load_data,
   output logic [DATA_W-1:0] o_store_word
);

   // Extend the addressed low bytes of the fetched word according to the access size.
   always_comb begin
      o_load_data = i_word;
      case (i_funct3)
         F3_B:    o_load_data = {{24{i_word[7]}}, i_word[7:0]};
         F3_BU:   o_load_data = {24'h000000, i_word[7:0]};
         F3_H:    o_load_data = {{16{i_word[15]}}, i_word[15:0]};
         F3_HU:   o_load_data = {16'h0000, i_word[15:0]};
         default: o_load_data = i_word;
      endcase
   end

   // Keep the untouched upper bytes of the old word, replace only the stored low bytes.
   always_comb begin
      o_store_word = i_wdata;
      case (i_funct3)
         F3_B:    o_store_word = {i_word[31:8], i_wdata[7:0]};
         F3_H:    o_store_word = {i_word[31:16], i_wdata[15:0]};
         default: o_store_word = i_wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a 4-byte-write data memory; SB/SH use read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses respond with an error instead of accessing memory.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [2:0]        i_req_funct3,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
   output logic              o_resp_valid,
   output logic [DATA_W-1:0] o_resp_rdata,
   output logic              o_resp_err,
   output logic              o_mem_rw,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   lsu_state_t        r_state;
   logic              r_we;
   logic [2:0]        r_funct3;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_req_ready;
   logic              r_resp_valid;
   logic [DATA_W-1:0] r_resp_rdata;
   logic              r_resp_err;
   logic              r_mem_rw;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;

   lsu_state_t        w_next_state;
   logic              w_accept;
   logic              w_misalign;
   logic              w_next_rw;
   logic [ADDR_W-1:0] w_next_addr;
   logic [DATA_W-1:0] w_next_wdata;
   logic [DATA_W-1:0] w_next_rdata;
   logic              w_next_err;
   logic [DATA_W-1:0] w_load_data;
   logic [DATA_W-1:0] w_store_word;

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_misalign = is_misaligned(i_req_funct3, i_req_addr[1:0]);
`else
   assign w_misalign = 1'b0;
`endif

   lsu_data_align #(.DATA_W(DATA_W)) u_align (
      .i_funct3     (r_funct3),
      .i_word       (i_mem_rdata),
      .i_wdata      (r_wdata),
      .o_load_data  (w_load_data),
      .o_store_word (w_store_word)
   );

   // Next state plus the value every registered output takes in that state; mem_rw is 0 only entering a write cycle.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_next_rw    = 1'b1;
      w_next_addr  = {ADDR_W{1'b0}};
      w_next_wdata = {DATA_W{1'b0}};
      w_next_rdata = {DATA_W{1'b0}};
      w_next_err   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_req_valid) begin
               w_accept = 1'b1;
               if (!is_legal(i_req_we, i_req_funct3) || w_misalign) begin
                  w_next_state = ST_RESP;
                  w_next_err   = 1'b1;
               end else begin
                  w_next_state = ST_ACCESS;
                  w_next_addr  = i_req_addr;
                  if (i_req_we && (i_req_funct3 == F3_W)) begin
                     w_next_rw    = 1'b0;
                     w_next_wdata = i_req_wdata;
                  end else begin
                     w_next_rw    = 1'b1;
                  end
               end
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (r_we) begin
               if (r_funct3 == F3_W) begin
                  w_next_state = ST_RESP;
               end else begin
                  w_next_state = ST_WRITE;
                  w_next_rw    = 1'b0;
                  w_next_addr  = r_addr;
                  w_next_wdata = w_store_word;
               end
            end else begin
               w_next_state = ST_RESP;
               w_next_rdata = w_load_data;
            end
         end
         ST_WRITE: w_next_state = ST_RESP;
         ST_RESP:  w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // State, request latch and registered outputs; reset drops any in-flight request with mem_rw held at read.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_we         <= 1'b0;
         r_funct3     <= 3'b000;
         r_addr       <= {ADDR_W{1'b0}};
         r_wdata      <= {DATA_W{1'b0}};
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= {DATA_W{1'b0}};
         r_resp_err   <= 1'b0;
         r_mem_rw     <= 1'b1;
         r_mem_addr   <= {ADDR_W{1'b0}};
         r_mem_wdata  <= {DATA_W{1'b0}};
      end else begin
         r_state      <= w_next_state;
         r_req_ready  <= (w_next_state == ST_IDLE);
         r_resp_valid <= (w_next_state == ST_RESP);
         r_resp_rdata <= w_next_rdata;
         r_resp_err   <= w_next_err;
         r_mem_rw     <= w_next_rw;
         r_mem_addr   <= w_next_addr;
         r_mem_wdata  <= w_next_wdata;
         if (w_accept) begin
            r_we     <= i_req_we;
            r_funct3 <= i_req_funct3;
            r_addr   <= i_req_addr;
            r_wdata  <= i_req_wdata;
         end
      end
   end

   assign o_req_ready  = r_req_ready;
   assign o_resp_valid = r_resp_valid;
   assign o_resp_rdata = r_resp_rdata;
   assign o_resp_err   = r_resp_err;
   assign o_mem_rw     = r_mem_rw;
   assign o_mem_addr   = r_mem_addr;
   assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-addressed memory model, directed cases and random traffic.
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_rw;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   logic       init_req;

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_we     (req_we),
      .i_req_funct3 (req_funct3),
      .i_req_addr   (req_addr),
      .i_req_wdata  (req_wdata),
      .o_resp_valid (resp_valid),
      .o_resp_rdata (resp_rdata),
      .o_resp_err   (resp_err),
      .o_mem_rw     (mem_rw),
      .o_mem_addr   (mem_addr),
      .o_mem_wdata  (mem_wdata),
      .i_mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // data_mem: combinational little-endian read, 4-byte write on every edge with rw=0
   always_comb begin
      logic [7:0] a;
      a = mem_addr[7:0];
      mem_rdata = {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)], mem[8'(a + 8'd1)], mem[a]};
   end

   always @(posedge clk) begin
      if (init_req) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      end else if (!mem_rw) begin
         for (int k = 0; k < 4; k++) mem[8'(mem_addr[7:0] + 8'(k))] <= mem_wdata[8*k +: 8];
      end
   end

   function automatic logic [31:0] tb_word(input logic [31:0] a);
      logic [7:0] b;
      b = a[7:0];
      return {mem[8'(b + 8'd3)], mem[8'(b + 8'd2)], mem[8'(b + 8'd1)], mem[b]};
   endfunction

   task automatic init_mem();
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);
      init_req = 1'b1;
      @(posedge clk);
      #1;
      init_req = 1'b0;
   endtask

   // Reference: what an access should do, from the access size and legality rules
   task automatic model_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] e_rdata, output logic e_err,
                            output int e_lat, output logic [7:0] e_mask, output logic [31:0] e_wdata);
      logic legal;
      logic trap;
      int   size;
      logic [31:0] val;
      legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
      size  = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
`ifdef LSU_MISALIGN_TRAP_EN
      trap = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
`else
      trap = 1'b0;
`endif
      e_rdata = 32'd0;
      e_err   = 1'b0;
      e_mask  = 8'd0;
      e_wdata = 32'd0;
      if (!legal || trap) begin
         e_err = 1'b1;
         e_lat = 1;
      end else if (we) begin
         for (int i = 0; i < size; i++) ref_mem[8'(addr[7:0] + 8'(i))] = wdata[8*i +: 8];
         for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = ref_mem[8'(addr[7:0] + 8'(i))];
         e_lat  = (size == 4) ? 2 : 3;
         e_mask = (size == 4) ? 8'b0000_0010 : 8'b0000_0100;
      end else begin
         val = 32'd0;
         for (int i = 0; i < size; i++) val[8*i +: 8] = ref_mem[8'(addr[7:0] + 8'(i))];
         if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
         e_rdata = val;
         e_lat   = 2;
      end
   endtask

   // Issue one request (DUT idle), track write cycles, wait for response, then step past RESP
   task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                          output int lat, output logic [7:0] wr_mask, output logic [31:0] wr_data,
                          output logic still_valid);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat     = -1;
      rdata   = 32'd0;
      err     = 1'b0;
      wr_mask = 8'd0;
      wr_data = 32'd0;
      for (int c = 1; c <= 8; c++) begin
         if (!mem_rw) begin
            wr_mask[c] = 1'b1;
            wr_data    = mem_wdata;
         end
         if (resp_valid) begin
            lat   = c;
            rdata = resp_rdata;
            err   = resp_err;
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      still_valid = resp_valid;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      init_mem();
      total_cnt++;
      if ({req_ready, resp_valid, resp_err, mem_rw} !== 4'b1001 || resp_rdata !== 32'd0 ||
          mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
         $display("FAIL reset_values: ready/valid/err/rw=%b rdata=%h addr=%h wdata=%h, required 1001 0 0 0",
                  {req_ready, resp_valid, resp_err, mem_rw}, resp_rdata, mem_addr, mem_wdata);
      end else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total_cnt++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_rw !== 1'b1) begin
         $display("FAIL post_reset_idle: ready=%b valid=%b rw=%b, required 1 0 1", req_ready, resp_valid, mem_rw);
      end else pass_cnt++;
   endtask

   task automatic test_loads();
      logic [31:0] addrs [5];
      logic [2:0]  f3s   [5];
      logic [31:0] exps  [5];
      logic [31:0] rd, wd, er;
      logic        e, sv, ee;
      int          lat, el;
      logic [7:0]  wm, em;
      addrs = '{32'h10, 32'h80, 32'h80, 32'h82, 32'h82};
      f3s   = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
      exps  = '{32'h13121110, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8382, 32'h00008382};
      for (int i = 0; i < 5; i++) begin
         model_txn(1'b0, f3s[i], addrs[i], 32'd0, er, ee, el, em, wd);
         run_txn(1'b0, f3s[i], addrs[i], 32'd0, rd, e, lat, wm, wd, sv);
         total_cnt++;
         if (rd !== exps[i] || e !== 1'b0) begin
            $display("FAIL load_%0d: rdata=%h err=%b, required %h err=0", i, rd, e, exps[i]);
         end else pass_cnt++;
         total_cnt++;
         if (lat !== 2 || wm !== 8'd0 || sv !== 1'b0) begin
            $display("FAIL load_timing_%0d: lat=%0d wrmask=%b held=%b, required 2 0 0", i, lat, wm, sv);
         end else pass_cnt++;
      end
   endtask

   task automatic test_store_rmw();
      logic [31:0] rd, wd, er, ew;
      logic        e, sv, ee;
      int          lat, el;
      logic [7:0]  wm, em;
      model_txn(1'b1, 3'b000, 32'h20, 32'hDEADBEAB, er, ee, el, em, ew);
      run_txn(1'b1, 3'b000, 32'h20, 32'hDEADBEAB, rd, e, lat, wm, wd, sv);
      total_cnt++;
      if (lat !== 3 || wm !== 8'b0000_0100 || wd !== 32'h232221AB || e !== 1'b0 || rd !== 32'd0) begin
         $display("FAIL sb_0x20: lat=%0d wrmask=%b wdata=%h err=%b rdata=%h, required 3 00000100 232221ab 0 0",
                  lat, wm, wd, e, rd);
      end else pass_cnt++;
      run_txn(1'b0, 3'b010, 32'h20, 32'd0, rd, e, lat, wm, wd, sv);
      total_cnt++;
      if (rd !== 32'h232221AB) $display("FAIL sb_readback: rdata=%h, required 232221ab", rd);
      else pass_cnt++;
      model_txn(1'b1, 3'b001, 32'h40, 32'h00001234, er, ee, el, em, ew);
      run_txn(1'b1, 3'b001, 32'h40, 32'h00001234, rd, e, lat, wm, wd, sv);
      total_cnt++;
      if (lat !== 3 || wm !== 8'b0000_0100 || wd !== 32'h43421234) begin
         $display("FAIL sh_0x40: lat=%0d wrmask=%b wdata=%h, required 3 00000100 43421234", lat, wm, wd);
      end else pass_cnt++;
      run_txn(1'b0, 3'b010, 32'h40, 32'd0, rd, e, lat, wm, wd, sv);
      total_cnt++;
      if (rd !== 32'h43421234) $display("FAIL sh_readback: rdata=%h, required 43421234", rd);
      else pass_cnt++;
      model_txn(1'b1, 3'b010, 32'h50, 32'hCAFEF00D, er, ee, el, em, ew);
      run_txn(1'b1, 3'b010, 32'h50, 32'hCAFEF00D, rd, e, lat, wm, wd, sv);
      total_cnt++;
      if (lat !== 2 || wm !== 8'b0000_0010 || wd !== 32'hCAFEF00D || tb_word(32'h50) !== 32'hCAFEF00D) begin
         $display("FAIL sw_0x50: lat=%0d wrmask=%b wdata=%h mem=%h, required 2 00000010 cafef00d cafef00d",
                  lat, wm, wd, tb_word(32'h50));
      end else pass_cnt++;
   endtask

   task automatic test_illegal();
      logic [31:0] rd, wd;
      logic        e, sv;
      int          lat;
      logic [7:0]  wm;
      run_txn(1'b0, 3'b011, 32'h60, 32'd0, rd, e, lat, wm, wd, sv);
      total_cnt++;
      if (lat !== 1 || e !== 1'b1 || rd !== 32'd0 || wm !== 8'd0) begin
         $display("FAIL illegal_load: lat=%0d err=%b rdata=%h wrmask=%b, required 1 1 0 0", lat, e, rd, wm);
      end else pass_cnt++;
      run_txn(1'b1, 3'b100, 32'h60, 32'hFFFFFFFF, rd, e, lat, wm, wd, sv);
      total_cnt++;
      if (lat !== 1 || e !== 1'b1 || rd !== 32'd0 || wm !== 8'd0 || tb_word(32'h60) !== 32'h63626160) begin
         $display("FAIL illegal_store: lat=%0d err=%b rdata=%h wrmask=%b mem=%h, required 1 1 0 0 63626160",
                  lat, e, rd, wm, tb_word(32'h60));
      end else pass_cnt++;
   endtask

   task automatic test_misalign();
      logic [31:0] rd, wd, er, ew;
      logic        e, sv, ee;
      int          lat, el;
      logic [7:0]  wm, em;
      model_txn(1'b0, 3'b010, 32'h11, 32'd0, er, ee, el, em, ew);
      run_txn(1'b0, 3'b010, 32'h11, 32'd0, rd, e, lat, wm, wd, sv);
      total_cnt++;
`ifdef LSU_MISALIGN_TRAP_EN
      if (rd !== 32'd0 || e !== 1'b1 || lat !== 1) begin
         $display("FAIL misaligned_lw: rdata=%h err=%b lat=%0d, required 0 1 1", rd, e, lat);
      end else pass_cnt++;
`else
      if (rd !== 32'h14131211 || e !== 1'b0 || lat !== 2) begin
         $display("FAIL misaligned_lw: rdata=%h err=%b lat=%0d, required 14131211 0 2", rd, e, lat);
      end else pass_cnt++;
`endif
      model_txn(1'b0, 3'b010, 32'hFFFFFFFD, 32'd0, er, ee, el, em, ew);
      run_txn(1'b0, 3'b010, 32'hFFFFFFFD, 32'd0, rd, e, lat, wm, wd, sv);
      total_cnt++;
      if (rd !== er || e !== ee || lat !== el) begin
         $display("FAIL wrap_lw: rdata=%h err=%b lat=%0d, required %h %b %0d", rd, e, lat, er, ee, el);
      end else pass_cnt++;
   endtask

   task automatic test_reset_during_write();
      logic [31:0] rd, wd;
      logic        e, sv;
      int          lat;
      logic [7:0]  wm;
      logic        saw_valid;
      init_mem();
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b000;
      req_addr   = 32'h30;
      req_wdata  = 32'h000000EE;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      total_cnt++;
      if (mem_rw !== 1'b0) $display("FAIL rst_write_phase: rw=%b, required 0", mem_rw);
      else pass_cnt++;
      #1;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (mem_rw !== 1'b1 || resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 32'd0) begin
         $display("FAIL rst_mid_write: rw=%b valid=%b ready=%b addr=%h, required 1 0 1 0",
                  mem_rw, resp_valid, req_ready, mem_addr);
      end else pass_cnt++;
      saw_valid = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         saw_valid = saw_valid | resp_valid;
      end
      total_cnt++;
      if (saw_valid !== 1'b0 || tb_word(32'h30) !== 32'h33323130) begin
         $display("FAIL rst_no_write: valid_seen=%b mem=%h, required 0 33323130", saw_valid, tb_word(32'h30));
      end else pass_cnt++;
      init_mem();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_txn(1'b0, 3'b010, 32'h30, 32'd0, rd, e, lat, wm, wd, sv);
      total_cnt++;
      if (rd !== 32'h33323130 || e !== 1'b0 || lat !== 2) begin
         $display("FAIL rst_readback: rdata=%h err=%b lat=%0d, required 33323130 0 2", rd, e, lat);
      end else pass_cnt++;
   endtask

   task automatic test_random();
      logic [31:0] rd, wd, er, ew, addr, wdata;
      logic        e, sv, ee, we;
      logic [2:0]  f3;
      int          lat, el, bad;
      logic [7:0]  wm, em;
      for (int n = 0; n < 80; n++) begin
         we    = 1'($urandom_range(0, 1));
         f3    = 3'($urandom_range(0, 7));
         addr  = $urandom;
         wdata = $urandom;
         if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
         model_txn(we, f3, addr, wdata, er, ee, el, em, ew);
         run_txn(we, f3, addr, wdata, rd, e, lat, wm, wd, sv);
         total_cnt++;
         if (rd !== er || e !== ee || lat !== el || wm !== em || sv !== 1'b0) begin
            $display("FAIL rand_%0d we=%b f3=%b addr=%h: rdata=%h err=%b lat=%0d wrmask=%b held=%b, required %h %b %0d %b 0",
                     n, we, f3, addr, rd, e, lat, wm, sv, er, ee, el, em);
         end else pass_cnt++;
         if (em != 8'd0) begin
            total_cnt++;
            if (wd !== ew) $display("FAIL rand_wdata_%0d: mem_wdata=%h, required %h", n, wd, ew);
            else pass_cnt++;
         end
      end
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
      total_cnt++;
      if (bad != 0) $display("FAIL final_memory: %0d differing bytes, required 0", bad);
      else pass_cnt++;
   endtask

   initial begin
      rst_n      = 1'b0;
      init_req   = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      test_reset();
      test_loads();
      test_store_rmw();
      test_illegal();
      test_misalign();
      test_reset_during_write();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
